traffic_fsm: RTL and testbench

- Sequencing controller for the four-phase intersection.
- Owns the 2-bit phase code consumed by the light decoder.
- Drives `state` from the phase timers and the approach sensors; the decoder maps `state` onto the six lamp signals.
- Timing is counted in `tick` pulses from the shared prescaler, so the block is independent of clock frequency.

---
 rtl/traffic_pkg.sv | 20 ++
 rtl/traffic_fsm_if.sv | 21 ++
 rtl/traffic_fsm_phase_timer.sv | 23 ++
 rtl/traffic_fsm.sv | 74 +++++++
 tb/tb_traffic_fsm.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - phase encoding and default durations shared by the controller and the lamp decoder
package traffic_pkg;

    typedef enum logic [1:0] {
        NS_GREEN  = 2'd0,
        NS_YELLOW = 2'd1,
        EW_GREEN  = 2'd2,
        EW_YELLOW = 2'd3
    } phase_t;

    localparam int GREEN_MIN_DEFAULT = 10;
    localparam int GREEN_MAX_DEFAULT = 30;
    localparam int YELLOW_T_DEFAULT  = 3;

    // Greens sit on even codes, yellows on odd codes.
    function automatic logic is_green(phase_t p);
        return ~p[0];
    endfunction

endpackage

// File: rtl/traffic_fsm_if.sv
// rtl/traffic_fsm_if.sv - tick/sensor inputs and phase outputs of the intersection controller
interface traffic_fsm_if;
    import traffic_pkg::*;

    logic   tick;
    logic   ns_sensor;
    logic   ew_sensor;
    phase_t state;
    logic   phase_change;

    modport master (
        output tick, ns_sensor, ew_sensor,
        input  state, phase_change
    );

    modport slave (
        input  tick, ns_sensor, ew_sensor,
        output state, phase_change
    );

endinterface

// File: rtl/traffic_fsm_phase_timer.sv
// rtl/traffic_fsm_phase_timer.sv - tick-gated saturating phase counter with synchronous clear
module phase_timer #(
    parameter int W   = 5,
    parameter int MAX = 30
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         clear,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && (count != W'(MAX))) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_fsm.sv
// rtl/traffic_fsm.sv - four-phase intersection sequencer driven by prescaler ticks and approach sensors
module traffic_fsm
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN = GREEN_MIN_DEFAULT,
    parameter int GREEN_MAX = GREEN_MAX_DEFAULT,
    parameter int YELLOW_T  = YELLOW_T_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    traffic_fsm_if.slave  bus
);

    localparam int TW = $clog2(GREEN_MAX + 1);
    localparam logic [TW-1:0] MIN_LAST = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] MAX_LAST = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] YEL_LAST = TW'(YELLOW_T - 1);

    phase_t          state_q;
    phase_t          state_d;
    logic            advance;
    logic            other_pend;
    logic            ns_pend;
    logic            ew_pend;
    logic            phase_change_q;
    logic [TW-1:0]   timer;

    phase_timer #(
        .W   (TW),
        .MAX (GREEN_MAX)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .tick  (bus.tick),
        .clear (advance),
        .count (timer)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= NS_GREEN;
            phase_change_q <= 1'b0;
            ns_pend        <= 1'b0;
            ew_pend        <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_change_q <= advance;
            // Entering a green consumes that approach's request, even one arriving this cycle.
            ns_pend <= (advance && state_d == NS_GREEN) ? 1'b0 : (ns_pend | bus.ns_sensor);
            ew_pend <= (advance && state_d == EW_GREEN) ? 1'b0 : (ew_pend | bus.ew_sensor);
        end
    end

    always_comb begin
        state_d    = state_q;
        advance    = 1'b0;
        other_pend = (state_q == NS_GREEN) ? ew_pend : ns_pend;
        if (bus.tick) begin
            if (is_green(state_q)) begin
                advance = (timer == MAX_LAST) || ((timer >= MIN_LAST) && other_pend);
            end else begin
                advance = (timer == YEL_LAST);
            end
        end
        // The encoding runs in service order, so the successor is simply the next code.
        if (advance) begin
            state_d = phase_t'(state_q + 2'd1);
        end
    end

    assign bus.state        = state_q;
    assign bus.phase_change = phase_change_q;

endmodule

// File: tb/tb_traffic_fsm.sv
// tb/tb_traffic_fsm.sv - directed self-checking bench for traffic_fsm
module tb_traffic_fsm;
    import traffic_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    traffic_fsm_if bus ();

    traffic_fsm #(
        .GREEN_MIN (2),
        .GREEN_MAX (5),
        .YELLOW_T  (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One tick period of 4 cycles; the tick is sampled on the first edge, and
    // the phase_change seen just after that edge is returned.
    task automatic tick_once(output logic pc);
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        pc = bus.phase_change;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_phase(input string tag, input int cur, input int n, input int nxt);
        logic pc;
        for (int i = 1; i <= n; i++) begin
            tick_once(pc);
            if (i < n) begin
                chk({tag, "_hold_state"}, bus.state, cur);
                chk({tag, "_hold_pc"}, pc, 1'b0);
            end else begin
                chk({tag, "_next_state"}, bus.state, nxt);
                chk({tag, "_next_pc"}, pc, 1'b1);
            end
        end
        chk({tag, "_pc_low"}, bus.phase_change, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic pc;
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        bus.tick      = 1'b0;
        bus.ns_sensor = 1'b0;
        bus.ew_sensor = 1'b0;

        #1;
        chk("rst_state", bus.state, 2'd0);
        chk("rst_pc", bus.phase_change, 1'b0);
        chk("rst_timer", dut.u_timer.count, 3'd0);
        chk("rst_ew_pend", dut.ew_pend, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 1: free-running fairness cycle
        run_phase("s1_nsg", 0, 5, 1);
        run_phase("s1_nsy", 1, 1, 2);
        run_phase("s1_ewg", 2, 5, 3);
        run_phase("s1_ewy", 3, 1, 0);

        // 2: EW request held from reset
        bus.ew_sensor = 1'b1;
        do_reset();
        run_phase("s2_nsg", 0, 2, 1);
        run_phase("s2_nsy", 1, 1, 2);
        bus.ew_sensor = 1'b0;

        // 3: single-cycle EW pulse after NS tick 4
        do_reset();
        for (int i = 1; i <= 4; i++) tick_once(pc);
        chk("s3_before_state", bus.state, 2'd0);
        chk("s3_before_pend", dut.ew_pend, 1'b0);
        bus.ew_sensor = 1'b1;
        @(negedge clk);
        bus.ew_sensor = 1'b0;
        chk("s3_pend_set", dut.ew_pend, 1'b1);
        run_phase("s3_nsg", 0, 1, 1);
        run_phase("s3_nsy", 1, 1, 2);
        chk("s3_pend_clr", dut.ew_pend, 1'b0);

        // 4: ticks frozen during EW green, NS request still latched
        tick_once(pc);
        chk("s4_t1_state", bus.state, 2'd2);
        chk("s4_t1_timer", dut.u_timer.count, 3'd1);
        repeat (50) @(negedge clk);
        bus.ns_sensor = 1'b1;
        @(negedge clk);
        bus.ns_sensor = 1'b0;
        repeat (49) @(negedge clk);
        chk("s4_frz_state", bus.state, 2'd2);
        chk("s4_frz_timer", dut.u_timer.count, 3'd1);
        chk("s4_frz_pend", dut.ns_pend, 1'b1);
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        chk("s4_exit_state", bus.state, 2'd3);
        chk("s4_exit_pc", bus.phase_change, 1'b1);

        // 5: asynchronous reset while phase_change is high in EW yellow
        #2;
        reset = 1'b1;
        #1;
        chk("s5_async_state", bus.state, 2'd0);
        chk("s5_async_pc", bus.phase_change, 1'b0);
        chk("s5_async_timer", dut.u_timer.count, 3'd0);
        chk("s5_async_pend", dut.ns_pend, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_phase("s5_nsg", 0, 5, 1);

        // 6: both approaches demanding service
        bus.ns_sensor = 1'b1;
        bus.ew_sensor = 1'b1;
        do_reset();
        run_phase("s6_nsg", 0, 2, 1);
        run_phase("s6_nsy", 1, 1, 2);
        run_phase("s6_ewg", 2, 2, 3);
        run_phase("s6_ewy", 3, 1, 0);
        run_phase("s6_nsg2", 0, 2, 1);
        bus.ns_sensor = 1'b0;
        bus.ew_sensor = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
